// File: rtl/edge_detect_filtered.sv
// Multi-channel edge detector: two-flop synchroniser, glitch filter, one-cycle
// edge pulse, sticky status and a combined interrupt request per instance.
module edge_detect_filtered #(
    parameter int Channels    = 1,
    parameter int EdgeType    = 0,
    parameter int FilterCount = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [Channels-1:0] d,
    input  logic                en,
    input  logic                clear,
    output logic [Channels-1:0] level,
    output logic [Channels-1:0] det,
    output logic [Channels-1:0] status,
    output logic                irq
);

    localparam int EdgeRising  = 0;
    localparam int EdgeFalling = 1;

    localparam int FiltLen = (FilterCount < 1) ? 1 : FilterCount;
    localparam int CntW    = ($clog2(FiltLen) < 1) ? 1 : $clog2(FiltLen);
    localparam logic [CntW-1:0] CntLast = CntW'(FiltLen - 1);

    if (EdgeType < 0 || EdgeType > 2) begin : gBadEdgeType
        $error("edge_detect_filtered: EdgeType must be 0, 1 or 2");
    end
    if (Channels < 1 || Channels > 8) begin : gBadChannels
        $error("edge_detect_filtered: Channels must be in 1..8");
    end
    if (FilterCount < 0 || FilterCount > 255) begin : gBadFilter
        $error("edge_detect_filtered: FilterCount must be in 0..255");
    end

    logic [Channels-1:0]           sync1_q;
    logic [Channels-1:0]           sync2_q;
    logic [Channels-1:0]           level_q;
    logic [Channels-1:0]           level_d;
    logic [Channels-1:0]           det_q;
    logic [Channels-1:0]           det_d;
    logic [Channels-1:0]           status_q;
    logic [Channels-1:0]           status_d;
    logic [Channels-1:0][CntW-1:0] cnt_q;
    logic [Channels-1:0][CntW-1:0] cnt_d;

    function automatic logic edgeSel(input logic oldLvl, input logic newLvl);
        case (EdgeType)
            EdgeRising:  return ~oldLvl & newLvl;
            EdgeFalling: return oldLvl & ~newLvl;
            default:     return oldLvl ^ newLvl;
        endcase
    endfunction

    // A level change is accepted only after FiltLen consecutive mismatching
    // samples; any return to the current level restarts the run.
    always_comb begin
        level_d = level_q;
        det_d   = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < Channels; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                level_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                det_d[i]   = en & edgeSel(level_q[i], sync2_q[i]);
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    // Set beats clear so an edge landing on the clear cycle is never lost.
    always_comb begin
        status_d = (status_q & ~{Channels{clear}}) | det_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            level_q  <= '0;
            det_q    <= '0;
            status_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= d;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            det_q    <= det_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level  = level_q;
    assign det    = det_q;
    assign status = status_q;
    assign irq    = |status_q;

endmodule
